// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the loadable MIPS instruction memory.
// Holds reset/halt addresses, the loader state enum and a byte-swap helper.
package mips_mem_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] HALT_ADDR    = 32'h00000000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } imem_state_t;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mips_instr_mem_array.sv
// Word storage with per-word written bits: one write port, one comb read.
// Ports: clk, reset_n (clears written bits), we/waddr/wdata, raddr/rdata.
module mips_instr_mem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0]            mem [DEPTH_WORDS];
  logic [DEPTH_WORDS-1:0] written;

  // Data needs no reset: the written bits mask stale contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      written <= '0;
    end else if (we) begin
      written[waddr] <= 1'b1;
    end
  end

  assign rdata = written[raddr] ? mem[raddr] : 32'h0;

endmodule

// File: rtl/mips_instr_memory.sv
// Loadable instruction memory for the Harvard CPU fetch port (macro MIPS_INSTR_BYTESWAP_EN swaps read lanes).
// Ports: clk, reset_n, load_valid/ready/data/last, cpu_reset, instr_address/readdata, halted, fetch_fault, load_overflow.
module mips_instr_memory
  import mips_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        cpu_reset,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  output logic        halted,
  output logic        fetch_fault,
  output logic        load_overflow
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  imem_state_t   state_q, state_d;
  logic [AW-1:0] cnt_q;
  logic          halted_q, fault_q, ovf_q;
  logic          accept, at_last;
  logic [31:0]   offset;
  logic          fetch_ok;
  logic [31:0]   word;

  assign accept  = load_valid & load_ready;
  assign at_last = (cnt_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = LOAD;
      LOAD: if (accept && (load_last || at_last)) state_d = RUN;
      RUN:  state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && !at_last) cnt_q <= cnt_q + 1'b1;
      if (accept && at_last && !load_last) ovf_q <= 1'b1;
      if (state_q == RUN) begin
        // Halt address wins over the fault flag.
        if (instr_address == HALT_ADDR) halted_q <= 1'b1;
        else if (!fetch_ok)             fault_q  <= 1'b1;
      end
    end
  end

  assign load_ready    = (state_q == LOAD);
  assign cpu_reset     = (state_q != RUN);
  assign halted        = halted_q;
  assign fetch_fault   = fault_q;
  assign load_overflow = ovf_q;

  // Offset wraps modulo 2^32, so addresses below the base are out of range.
  assign offset   = instr_address - BASE_ADDR;
  assign fetch_ok = (offset[1:0] == 2'b00) &&
                    ((offset >> 2) < 32'(DEPTH_WORDS));

  mips_instr_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (accept),
    .waddr  (cnt_q),
    .wdata  (load_data),
    .raddr  (offset[AW+1:2]),
    .rdata  (word)
  );

`ifdef MIPS_INSTR_BYTESWAP_EN
  assign instr_readdata = fetch_ok ? bswap32(word) : 32'h0;
`else
  assign instr_readdata = fetch_ok ? word : 32'h0;
`endif

endmodule

// File: tb/tb_mips_instr_memory.sv
// Self-checking bench for mips_instr_memory: table vectors, corner sequences
// and randomized loads/fetches against a behavioural model.
module tb_mips_instr_memory;

  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam int          DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;
  logic        cpu_reset;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        halted;
  logic        fetch_fault;
  logic        load_overflow;

  always #5 clk = ~clk;

  mips_instr_memory dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_data     (load_data),
    .load_last     (load_last),
    .cpu_reset     (cpu_reset),
    .instr_address (instr_address),
    .instr_readdata(instr_readdata),
    .halted        (halted),
    .fetch_fault   (fetch_fault),
    .load_overflow (load_overflow)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic chkb(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, a, e);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_started, m_run, m_halt, m_fault, m_ovf;
  int          m_cnt;
  logic [31:0] m_mem [int];

  function automatic logic [31:0] lane(input logic [31:0] w);
`ifdef MIPS_INSTR_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic bit m_valid(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off % 4 == 0) && (off / 4 < DEPTH);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] off;
    int idx;
    off = a - BASE;
    if (!m_valid(a)) return 32'h0;
    idx = int'(off / 4);
    if (!m_mem.exists(idx)) return 32'h0;
    return lane(m_mem[idx]);
  endfunction

  task automatic model_clear();
    m_mem.delete();
    m_started = 0;
    m_run     = 0;
    m_halt    = 0;
    m_fault   = 0;
    m_ovf     = 0;
    m_cnt     = 0;
  endtask

  function automatic bit m_ready();
    return m_started && !m_run;
  endfunction

  task automatic model_edge();
    if (!reset_n) begin
      model_clear();
    end else if (!m_started) begin
      m_started = 1;
    end else if (!m_run) begin
      if (load_valid) begin
        m_mem[m_cnt] = load_data;
        if (load_last || m_cnt == DEPTH - 1) begin
          m_run = 1;
          if (!load_last) m_ovf = 1;
        end else begin
          m_cnt++;
        end
      end
    end else begin
      if (instr_address == 32'h0) m_halt = 1;
      else if (!m_valid(instr_address)) m_fault = 1;
    end
  endtask

  task automatic check_outputs(input string t);
    chkb({t, ".load_ready"}, load_ready, m_ready());
    chkb({t, ".cpu_reset"}, cpu_reset, !m_run);
    chkb({t, ".halted"}, halted, m_halt);
    chkb({t, ".fetch_fault"}, fetch_fault, m_fault);
    chkb({t, ".load_overflow"}, load_overflow, m_ovf);
    chk({t, ".readdata"}, instr_readdata, m_read(instr_address));
  endtask

  task automatic half1(input string t);
    @(negedge clk);
    check_outputs(t);
  endtask

  task automatic half2();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    reset_n       = 1'b0;
    load_valid    = 1'b0;
    load_last     = 1'b0;
    load_data     = 32'h0;
    instr_address = BASE;
    model_clear();
    #1;
    check_outputs("reset");
    repeat (2) begin
      half1("reset_hold");
      half2();
    end
    reset_n = 1'b1;
  endtask

  // ---------------- load driver ----------------
  logic [31:0] prog[$];
  int          rdy_hi;

  task automatic load_prog(input bit use_last, input int gap_pct,
                           input int n);
    int  i     = 0;
    int  guard = 0;
    bit  acc;
    rdy_hi = 0;
    while (i < n && guard < 3000) begin
      load_valid = ($urandom_range(99) >= gap_pct);
      load_data  = prog[i];
      load_last  = use_last && (i == prog.size() - 1);
      half1("load");
      if (load_ready === 1'b1) rdy_hi++;
      acc = load_valid && m_ready();
      half2();
      if (acc) i++;
      guard++;
    end
    chk("load_done", i, n);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rd;
    logic        flt;
  } fvec_t;

  fvec_t tbl[7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          k;

`ifdef MIPS_INSTR_BYTESWAP_EN
    tbl[0] = '{32'hBFC00000, 32'h06608424, 1'b0};
    tbl[1] = '{32'hBFC00004, 32'h0610A400, 1'b0};
    tbl[2] = '{32'hBFC00008, 32'h08000000, 1'b0};
`else
    tbl[0] = '{32'hBFC00000, 32'h24846006, 1'b0};
    tbl[1] = '{32'hBFC00004, 32'h00A41006, 1'b0};
    tbl[2] = '{32'hBFC00008, 32'h00000008, 1'b0};
`endif
    tbl[3] = '{32'hBFC0000C, 32'h00000000, 1'b0};
    tbl[4] = '{32'hBFC003FC, 32'h00000000, 1'b0};
    tbl[5] = '{32'hBFC00400, 32'h00000000, 1'b1};
    tbl[6] = '{32'hBFC00002, 32'h00000000, 1'b1};

    // Three-word program: ready for 3 cycles, CPU released on the 4th.
    apply_reset();
    prog = '{32'h24846006, 32'h00A41006, 32'h00000008};
    load_prog(1'b1, 0, 3);
    chk("ready_cycles", rdy_hi, 3);
    half1("after_load");
    chkb("cpu_reset_4th", cpu_reset, 1'b0);
    half2();

    // Halt fetch: halted next cycle, no fault.
    instr_address = 32'h0;
    half1("halt_fetch");
    chk("halt_rd", instr_readdata, 32'h0);
    half2();
    instr_address = BASE;
    half1("halt_after");
    chkb("halt_set", halted, 1'b1);
    chkb("halt_nofault", fetch_fault, 1'b0);
    half2();

    // Table-driven fetch vectors.
    for (int i = 0; i < 7; i++) begin
      instr_address = tbl[i].addr;
      half1("tbl");
      chk($sformatf("tbl%0d_rd", i), instr_readdata, tbl[i].rd);
      half2();
      instr_address = BASE;
      half1("tbl_post");
      chkb($sformatf("tbl%0d_fault", i), fetch_fault, tbl[i].flt);
      half2();
    end

    // Full-depth load without last: overflow, then no more accepts.
    apply_reset();
    prog.delete();
    for (int i = 0; i < DEPTH; i++) prog.push_back($urandom);
    load_prog(1'b0, 0, DEPTH);
    load_valid    = 1'b1;
    load_data     = $urandom;
    instr_address = BASE + 32'd1020;
    half1("ovf");
    chkb("ovf_set", load_overflow, 1'b1);
    chkb("ovf_ready", load_ready, 1'b0);
    chkb("ovf_run", cpu_reset, 1'b0);
    chk("ovf_last_word", instr_readdata, lane(prog[DEPTH-1]));
    half2();
    half1("ovf2");
    half2();
    load_valid = 1'b0;

    // Reset pulse mid-load discards the partial program.
    apply_reset();
    prog = '{$urandom | 32'h1, $urandom, $urandom, $urandom, $urandom};
    load_prog(1'b1, 0, 2);
    instr_address = BASE;
    #1;
    chk("partial_word0", instr_readdata, lane(prog[0]));
    reset_n = 1'b0;
    model_clear();
    #1;
    chk("mid_rst_rd", instr_readdata, 32'h0);
    chkb("mid_rst_cpu", cpu_reset, 1'b1);
    chkb("mid_rst_ready", load_ready, 1'b0);
    chkb("mid_rst_ovf", load_overflow, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    half1("rel");
    chkb("rel_ready_lo", load_ready, 1'b0);
    half2();
    half1("rel1");
    chkb("rel_ready_hi", load_ready, 1'b1);
    half2();
    load_prog(1'b1, 20, 5);

    // Randomized programs and fetches.
    repeat (4) begin
      apply_reset();
      prog.delete();
      k = $urandom_range(1, 60);
      for (int i = 0; i < k; i++) prog.push_back($urandom);
      load_prog(1'b1, 30, k);
      repeat (150) begin
        k = $urandom_range(0, 9);
        a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        if (k == 5) a = a + 32'($urandom_range(1, 3));
        if (k == 6) a = BASE + 32'd1024 + 32'(4 * $urandom_range(0, 1000));
        if (k == 7) a = BASE - 32'(4 * $urandom_range(1, 1000));
        if (k == 8) a = 32'h0;
        if (k == 9) a = $urandom;
        instr_address = a;
        half1("rand");
        half2();
      end
      half1("rand_end");
      half2();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
